// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Optional build macro (used by clk_div_multi): CLK_DIV_MULTI_SYNC_EN.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 11;
  localparam int DEF_DIV_DEF = 10;

  // Board clock feeding every divider channel.
  localparam int unsigned CLK_HZ = 50_000_000;

  // What a channel does in a given cycle; resolved once per cycle, in priority order.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,  // channel disabled: counter parked at 0
    MODE_SYNC = 2'd1,  // global phase-align pulse
    MODE_TERM = 2'd2,  // terminal count reached
    MODE_RUN  = 2'd3   // counting up
  } chan_mode_e;

  // Divisor that gives a divided clock of f_hz from CLK_HZ.
  // A half period spans div+1 input cycles, hence the -1.
  function automatic int unsigned div_for_hz(input int unsigned f_hz);
    int unsigned half_cycles;
    half_cycles = CLK_HZ / (2 * f_hz);
    div_for_hz  = (half_cycles == 0) ? 0 : half_cycles - 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: up-counter against an active divisor, with a
// pending-divisor register so that a new divisor only takes effect on
// a period boundary (counter back at 0).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             term_cnt;
  chan_mode_e       mode;

  // Decide what this cycle is: disabled, sync, terminal count or plain count.
  always_comb begin
    term_cnt = (cnt_q == div_act_q);
    mode     = MODE_RUN;
    if (!en_i) begin
      mode = MODE_IDLE;
    end else if (sync_i) begin
      mode = MODE_SYNC;
    end else if (term_cnt) begin
      mode = MODE_TERM;
    end
  end

  // Next-state for counter, divisors and outputs.
  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;

    unique case (mode)
      MODE_IDLE: begin
        // Stopped: no period in flight, so a divisor can switch straight away.
        cnt_d = '0;
        if (load_i) begin
          div_act_d  = div_i;
          div_pend_d = div_i;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end
      MODE_SYNC: begin
        // Restart the period from a known phase; no tick for this cycle.
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end
      MODE_TERM: begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = 1'b1;
        if (pend_q) begin
          div_act_d = div_pend_q;
          pend_d    = 1'b0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
      end
    endcase

    // A load while running always parks in div_pend; it overrides the
    // clear above, so a load coincident with terminal count waits a period.
    if (load_i && en_i) begin
      div_pend_d = div_i;
      pend_d     = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      div_act_q  <= DEF_DIV_V;
      div_pend_q <= DEF_DIV_V;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider (top level).
// Build macro CLK_DIV_MULTI_SYNC_EN adds sync_i, a one-cycle pulse that
// phase-aligns all enabled channels; without it channels free-run.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef CLK_DIV_MULTI_SYNC_EN
  input  logic                 sync_i,
`endif
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH-1:0]       load_i,
  input  logic [NCH*CNT_W-1:0] div_i,
  output logic [NCH-1:0]       clk_o,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       pend_o
);

  logic sync_w;

`ifdef CLK_DIV_MULTI_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // One independent divider per channel, each fed its own divisor slice.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i[k]),
      .load_i (load_i[k]),
      .sync_i (sync_w),
      .div_i  (div_i[k*CNT_W +: CNT_W]),
      .clk_o  (clk_o[k]),
      .tick_o (tick_o[k]),
      .pend_o (pend_o[k])
    );
  end

endmodule
